// File: rtl/fpu_issue_ctrl.sv
// Issue/handshake controller in front of FPU_all: latches one FP op, drives the FPU, returns the result, owns fcsr.
// Optional watchdog in EXEC is compiled in when FPU_TIMEOUT_EN is defined.
module fpu_issue_ctrl #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_funct7,
    input  logic [2:0]        req_rm,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [4:0]        req_rd,
    input  logic              req_lw,
    input  logic              req_sw,
    input  logic [DATA_W-1:0] req_load_data,
    output logic [4:0]        f_rs1,
    output logic [4:0]        f_rs2,
    output logic [4:0]        f_rd,
    output logic [2:0]        frm_in,
    output logic [7:0]        f_funct_7,
    output logic              f_LW,
    output logic              f_SW,
    output logic [DATA_W-1:0] dload_ext,
    input  logic [DATA_W-1:0] FPU_all_out,
    input  logic [4:0]        f_flags,
    input  logic              f_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_illegal,
    output logic              resp_timeout,
    input  logic              csr_we,
    input  logic [1:0]        csr_addr,
    input  logic [7:0]        csr_wdata,
    output logic [7:0]        csr_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 127) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 7-bit watchdog counter");
    end

    state_t state;
    state_t state_next;

    logic [7:0]        funct7_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [4:0]        rd_q;
    logic              lw_q;
    logic              sw_q;
    logic [DATA_W-1:0] load_q;
    logic [2:0]        rm_q;
    logic [DATA_W-1:0] data_q;
    logic              illegal_q;
    logic [4:0]        fflags_q;
    logic [2:0]        frm_q;
    logic [4:0]        fflags_next;
    logic [2:0]        frm_next;

    logic [2:0] rm_eff;
    logic       rm_bad;
    logic       accept;
    logic       done_ok;
    logic       timeout_fire;
    logic       in_exec;
    logic       in_resp;

    // Dynamic rounding uses the frm value present before any same-edge CSR write.
    assign rm_eff  = (req_rm == 3'b111) ? frm_q : req_rm;
    assign rm_bad  = (rm_eff == 3'b101) || (rm_eff == 3'b110) || (rm_eff == 3'b111);
    assign accept  = (state == IDLE) && req_valid;
    assign in_exec = (state == EXEC);
    assign in_resp = (state == RESP);
    assign done_ok = in_exec && f_ready;

`ifdef FPU_TIMEOUT_EN
    localparam logic [6:0]        TIMEOUT_LAST = 7'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] QNAN         = DATA_W'(32'h7FC0_0000);

    logic [6:0] cnt_q;
    logic       timeout_q;

    assign timeout_fire = in_exec && !f_ready && (cnt_q == TIMEOUT_LAST);
    assign resp_timeout = in_resp && timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q     <= '0;
                timeout_q <= 1'b0;
            end else if (in_exec) begin
                cnt_q <= cnt_q + 7'd1;
                if (timeout_fire) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign resp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = rm_bad ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (f_ready || timeout_fire) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct7_q  <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            lw_q      <= 1'b0;
            sw_q      <= 1'b0;
            load_q    <= '0;
            rm_q      <= '0;
            data_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                funct7_q  <= req_funct7;
                rs1_q     <= req_rs1;
                rs2_q     <= req_rs2;
                rd_q      <= req_rd;
                lw_q      <= req_lw;
                sw_q      <= req_sw;
                load_q    <= req_load_data;
                rm_q      <= rm_eff;
                illegal_q <= rm_bad;
                data_q    <= '0;
            end else if (done_ok) begin
                data_q <= FPU_all_out;
            end
`ifdef FPU_TIMEOUT_EN
            else if (timeout_fire) begin
                data_q <= QNAN;
            end
`endif
        end
    end

    // A same-edge CSR write replaces the flags first; completing-op flags are then OR-ed on top.
    always_comb begin
        fflags_next = fflags_q;
        frm_next    = frm_q;
        if (csr_we) begin
            case (csr_addr)
                2'b01: fflags_next = csr_wdata[4:0];
                2'b10: frm_next    = csr_wdata[2:0];
                2'b11: begin
                    fflags_next = csr_wdata[4:0];
                    frm_next    = csr_wdata[7:5];
                end
                default: ;
            endcase
        end
        if (done_ok && !lw_q && !sw_q) begin
            fflags_next = fflags_next | f_flags;
        end
        if (timeout_fire) begin
            fflags_next[4] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags_q <= '0;
            frm_q    <= '0;
        end else begin
            fflags_q <= fflags_next;
            frm_q    <= frm_next;
        end
    end

    always_comb begin
        csr_rdata = 8'h00;
        case (csr_addr)
            2'b01:   csr_rdata = {3'b000, fflags_q};
            2'b10:   csr_rdata = {5'b00000, frm_q};
            2'b11:   csr_rdata = {frm_q, fflags_q};
            default: csr_rdata = 8'h00;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // FPU lines are only live in EXEC, so an illegal op never reaches FPU_all.
    assign f_rs1     = in_exec ? rs1_q    : '0;
    assign f_rs2     = in_exec ? rs2_q    : '0;
    assign f_rd      = in_exec ? rd_q     : '0;
    assign frm_in    = in_exec ? rm_q     : '0;
    assign f_funct_7 = in_exec ? funct7_q : '0;
    assign f_LW      = in_exec && lw_q;
    assign f_SW      = in_exec && sw_q;
    assign dload_ext = in_exec ? load_q   : '0;

    assign resp_valid   = in_resp;
    assign resp_data    = in_resp ? data_q : '0;
    assign resp_rd      = in_resp ? rd_q   : '0;
    assign resp_illegal = in_resp && illegal_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed cases plus randomized traffic against a transaction-level model.
// Define FPU_TIMEOUT_EN for both files to exercise the watchdog case.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_funct7 = '0;
    logic [2:0]  req_rm = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [4:0]  req_rd = '0;
    logic        req_lw = 1'b0;
    logic        req_sw = 1'b0;
    logic [31:0] req_load_data = '0;
    logic [4:0]  f_rs1, f_rs2, f_rd;
    logic [2:0]  frm_in;
    logic [7:0]  f_funct_7;
    logic        f_LW, f_SW;
    logic [31:0] dload_ext;
    logic [31:0] FPU_all_out = '0;
    logic [4:0]  f_flags = '0;
    logic        f_ready = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_illegal;
    logic        resp_timeout;
    logic        csr_we = 1'b0;
    logic [1:0]  csr_addr = 2'b00;
    logic [7:0]  csr_wdata = '0;
    logic [7:0]  csr_rdata;
    logic        busy;

    int passed = 0;
    int total  = 0;

    fpu_issue_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct7(req_funct7), .req_rm(req_rm),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_lw(req_lw), .req_sw(req_sw), .req_load_data(req_load_data),
        .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd), .frm_in(frm_in), .f_funct_7(f_funct_7),
        .f_LW(f_LW), .f_SW(f_SW), .dload_ext(dload_ext),
        .FPU_all_out(FPU_all_out), .f_flags(f_flags), .f_ready(f_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_rd(resp_rd),
        .resp_illegal(resp_illegal), .resp_timeout(resp_timeout),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Transaction-level model: phase 0 = waiting for op, 1 = op at the FPU, 2 = response pending.
    int          m_phase = 0;
    int          m_cnt = 0;
    logic [7:0]  m_funct7 = '0;
    logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic        m_lw = 1'b0, m_sw = 1'b0;
    logic [31:0] m_load = '0, m_data = '0;
    logic [2:0]  m_rm = '0;
    logic        m_illegal = 1'b0, m_timeout = 1'b0;
    logic [4:0]  m_fflags = '0;
    logic [2:0]  m_frm = '0;
    logic [4:0]  m_nf;
    logic [2:0]  m_nfrm;
    logic [2:0]  m_req_rm;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_funct7 = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            m_lw = 1'b0; m_sw = 1'b0; m_load = '0; m_data = '0; m_rm = '0;
            m_illegal = 1'b0; m_timeout = 1'b0; m_fflags = '0; m_frm = '0;
        end else begin
            m_nf   = m_fflags;
            m_nfrm = m_frm;
            if (csr_we) begin
                if (csr_addr == 2'b01) m_nf = csr_wdata[4:0];
                if (csr_addr == 2'b10) m_nfrm = csr_wdata[2:0];
                if (csr_addr == 2'b11) begin
                    m_nf   = csr_wdata[4:0];
                    m_nfrm = csr_wdata[7:5];
                end
            end
            if (m_phase == 0) begin
                if (req_valid) begin
                    m_req_rm = (req_rm == 3'b111) ? m_frm : req_rm;
                    m_rm = m_req_rm; m_funct7 = req_funct7; m_rs1 = req_rs1; m_rs2 = req_rs2;
                    m_rd = req_rd; m_lw = req_lw; m_sw = req_sw; m_load = req_load_data;
                    m_timeout = 1'b0;
                    m_data = 32'h0;
                    if (m_req_rm > 3'd4) begin
                        m_phase = 2;
                        m_illegal = 1'b1;
                    end else begin
                        m_phase = 1;
                        m_illegal = 1'b0;
                        m_cnt = 0;
                    end
                end
            end else if (m_phase == 1) begin
                if (f_ready) begin
                    m_data = FPU_all_out;
                    if (!m_lw && !m_sw) m_nf = m_nf | f_flags;
                    m_phase = 2;
                end else begin
`ifdef FPU_TIMEOUT_EN
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 64) begin
                        m_phase = 2;
                        m_timeout = 1'b1;
                        m_data = 32'h7FC0_0000;
                        m_nf[4] = 1'b1;
                    end
`endif
                end
            end else begin
                if (resp_ready) m_phase = 0;
            end
            m_fflags = m_nf;
            m_frm    = m_nfrm;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    function automatic logic [7:0] exp_csr(input logic [1:0] a);
        case (a)
            2'b01:   return {3'b000, m_fflags};
            2'b10:   return {5'b00000, m_frm};
            2'b11:   return {m_frm, m_fflags};
            default: return 8'h00;
        endcase
    endfunction

    // Every cycle: all DUT outputs against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        checkOutput("req_ready",    {31'b0, req_ready},    {31'b0, m_phase == 0});
        checkOutput("busy",         {31'b0, busy},         {31'b0, m_phase != 0});
        checkOutput("f_rs1",        {27'b0, f_rs1},        (m_phase == 1) ? {27'b0, m_rs1} : 32'h0);
        checkOutput("f_rs2",        {27'b0, f_rs2},        (m_phase == 1) ? {27'b0, m_rs2} : 32'h0);
        checkOutput("f_rd",         {27'b0, f_rd},         (m_phase == 1) ? {27'b0, m_rd} : 32'h0);
        checkOutput("frm_in",       {29'b0, frm_in},       (m_phase == 1) ? {29'b0, m_rm} : 32'h0);
        checkOutput("f_funct_7",    {24'b0, f_funct_7},    (m_phase == 1) ? {24'b0, m_funct7} : 32'h0);
        checkOutput("f_LW",         {31'b0, f_LW},         {31'b0, (m_phase == 1) && m_lw});
        checkOutput("f_SW",         {31'b0, f_SW},         {31'b0, (m_phase == 1) && m_sw});
        checkOutput("dload_ext",    dload_ext,             (m_phase == 1) ? m_load : 32'h0);
        checkOutput("resp_valid",   {31'b0, resp_valid},   {31'b0, m_phase == 2});
        checkOutput("resp_data",    resp_data,             (m_phase == 2) ? m_data : 32'h0);
        checkOutput("resp_rd",      {27'b0, resp_rd},      (m_phase == 2) ? {27'b0, m_rd} : 32'h0);
        checkOutput("resp_illegal", {31'b0, resp_illegal}, {31'b0, (m_phase == 2) && m_illegal});
        checkOutput("resp_timeout", {31'b0, resp_timeout}, {31'b0, (m_phase == 2) && m_timeout});
        checkOutput("csr_rdata",    {24'b0, csr_rdata},    {24'b0, exp_csr(csr_addr)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        int r;
        req_valid     = 1'($urandom_range(0, 1));
        req_funct7    = 8'($urandom);
        req_rm        = 3'($urandom);
        req_rs1       = 5'($urandom);
        req_rs2       = 5'($urandom);
        req_rd        = 5'($urandom);
        r             = int'($urandom_range(0, 3));
        req_lw        = (r == 0);
        req_sw        = (r == 1);
        req_load_data = $urandom;
        f_ready       = ($urandom_range(0, 2) == 0);
        FPU_all_out   = $urandom;
        f_flags       = 5'($urandom);
        resp_ready    = 1'($urandom_range(0, 1));
        csr_we        = ($urandom_range(0, 7) == 0);
        csr_addr      = 2'($urandom);
        csr_wdata     = 8'($urandom);
    endtask

    initial begin
        tick();
        tick();
        @(negedge clk);
        csr_addr = 2'b11;
        #1;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("rst_fcsr", {24'b0, csr_rdata}, 32'h0);
        tick();
        rst = 1'b0;

        // fadd with rm=000, result three cycles after accept
        tick();
        req_valid = 1'b1; req_funct7 = 8'h00; req_rm = 3'b000; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd3;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("t1_frm_in", {29'b0, frm_in}, 32'h0);
        checkOutput("t1_f_rs1", {27'b0, f_rs1}, 32'd1);
        tick();
        tick();
        f_ready = 1'b1; FPU_all_out = 32'h4040_0000; f_flags = 5'b00001;
        tick();
        f_ready = 1'b0; csr_addr = 2'b01;
        @(negedge clk);
        checkOutput("t1_resp_data", resp_data, 32'h4040_0000);
        checkOutput("t1_resp_rd", {27'b0, resp_rd}, 32'd3);
        checkOutput("t1_fflags", {24'b0, csr_rdata}, 32'h01);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // dynamic rounding from frm, then an illegal dynamic mode
        csr_we = 1'b1; csr_addr = 2'b10; csr_wdata = 8'h02;
        tick();
        csr_we = 1'b0;
        req_valid = 1'b1; req_rm = 3'b111; req_funct7 = 8'h10;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("t2_frm_in", {29'b0, frm_in}, 32'h2);
        checkOutput("t2_funct7", {24'b0, f_funct_7}, 32'h10);
        f_ready = 1'b1; f_flags = 5'b00000; FPU_all_out = 32'h3F00_0000;
        tick();
        f_ready = 1'b0; resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        csr_we = 1'b1; csr_addr = 2'b10; csr_wdata = 8'h05;
        tick();
        csr_we = 1'b0; csr_addr = 2'b01;
        req_valid = 1'b1; req_rm = 3'b111; req_funct7 = 8'h10;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("t2_illegal", {31'b0, resp_illegal}, 32'h1);
        checkOutput("t2_ill_funct7", {24'b0, f_funct_7}, 32'h0);
        checkOutput("t2_ill_data", resp_data, 32'h0);
        checkOutput("t2_fflags", {24'b0, csr_rdata}, 32'h01);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        csr_we = 1'b1; csr_addr = 2'b10; csr_wdata = 8'h00;
        tick();
        csr_we = 1'b0; csr_addr = 2'b01;

        // load op: flags of a load never reach fflags
        req_valid = 1'b1; req_lw = 1'b1; req_load_data = 32'hDEAD_BEEF; req_rm = 3'b000; req_rd = 5'd9;
        tick();
        req_valid = 1'b0; req_lw = 1'b0;
        @(negedge clk);
        checkOutput("t3_f_LW", {31'b0, f_LW}, 32'h1);
        checkOutput("t3_dload", dload_ext, 32'hDEAD_BEEF);
        f_ready = 1'b1; f_flags = 5'b11111; FPU_all_out = 32'h1234_5678;
        tick();

        // response held five cycles with a new request waiting and stray f_ready
        req_valid = 1'b1; req_funct7 = 8'h21; req_rm = 3'b000; req_rd = 5'd7;
        for (int i = 0; i < 5; i++) begin
            FPU_all_out = $urandom;
            @(negedge clk);
            checkOutput("t3_fflags", {24'b0, csr_rdata}, 32'h01);
            checkOutput("t4_hold_data", resp_data, 32'h1234_5678);
            checkOutput("t4_req_ready", {31'b0, req_ready}, 32'h0);
            tick();
        end
        f_ready = 1'b0; resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("t4_idle_ready", {31'b0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("t4_accepted", {24'b0, f_funct_7}, 32'h21);

        // CSR write and flag accumulation on the same edge
        csr_we = 1'b1; csr_addr = 2'b01; csr_wdata = 8'h04;
        f_ready = 1'b1; f_flags = 5'b00010; FPU_all_out = 32'h3F80_0000;
        tick();
        csr_we = 1'b0; f_ready = 1'b0;
        @(negedge clk);
        checkOutput("t5_fflags", {24'b0, csr_rdata}, 32'h06);
        checkOutput("t5_resp_data", resp_data, 32'h3F80_0000);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

`ifdef FPU_TIMEOUT_EN
        // watchdog with f_ready never asserted
        req_valid = 1'b1; req_rm = 3'b000; req_funct7 = 8'h01;
        tick();
        req_valid = 1'b0;
        repeat (63) tick();
        @(negedge clk);
        checkOutput("t6_not_yet", {31'b0, resp_valid}, 32'h0);
        tick();
        @(negedge clk);
        checkOutput("t6_timeout", {31'b0, resp_timeout}, 32'h1);
        checkOutput("t6_qnan", resp_data, 32'h7FC0_0000);
        checkOutput("t6_nv", {31'b0, csr_rdata[4]}, 32'h1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
`endif

        // asynchronous reset in the middle of EXEC
        req_valid = 1'b1; req_rm = 3'b000; req_funct7 = 8'h55;
        tick();
        req_valid = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("mid_funct7", {24'b0, f_funct_7}, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("mid_rst_funct7", {24'b0, f_funct_7}, 32'h0);
        checkOutput("mid_rst_busy", {31'b0, busy}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            applyStimulus();
            tick();
        end

        req_valid = 1'b0; f_ready = 1'b0; csr_we = 1'b0; resp_ready = 1'b1;
        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
